// File: rtl/dot_seq_pkg.sv
// Shared definitions for the dot-product sequencer: FSM state encoding,
// default accumulator width and the saturating pair counter helper.
package dot_seq_pkg;

   localparam int ACC_W_DEF = 20;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] c);
      return (c == 8'hFF) ? c : c + 8'd1;
   endfunction

endpackage

// File: rtl/Adder.sv
// Library adder: W-bit combinational sum, carry-out discarded (wraps).
module Adder #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/Register.sv
// Library register: synchronous active-low clear to zero, load on enable.
module Register #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_L,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/dot_seq.sv
// Dot-product sequencer: accepts one operand pair at a time, drives an external
// shift-add multiplier and accumulates the signed products until the last pair.
//
// Handshakes: a transfer on either side happens on a rising clk edge where both
// valid and ready are 1 (in_valid/in_ready, res_valid/res_ready); a valid held
// without ready keeps its payload stable.
module dot_seq
   import dot_seq_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_A,
   input  logic [7:0]       in_B,
   input  logic             in_last,
   output logic             mul_start,
   output logic [7:0]       mul_A,
   output logic [7:0]       mul_B,
   input  logic             mul_done,
   input  logic [15:0]      mul_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ACC_W-1:0] res_sum,
   output logic [7:0]       res_count,
   output state_t           dbg_state
);

   state_t           state;
   state_t           state_nx;
   logic [7:0]       op_a;
   logic [7:0]       op_b;
   logic             op_last;
   logic             first_wait;
   logic [7:0]       count;
   logic             accept;
   logic             acc_en;
   logic             acc_clr;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W-1:0] acc_sum;
   logic [ACC_W-1:0] prod_ext;

   assign prod_ext = ACC_W'(signed'(mul_out));
   assign acc_d    = acc_clr ? '0 : acc_sum;

   Adder #(.W(ACC_W)) u_add (
      .a   (acc),
      .b   (prod_ext),
      .sum (acc_sum)
   );

   Register #(.W(ACC_W)) u_acc (
      .clk     (clk),
      .reset_L (reset_L),
      .en      (acc_en | acc_clr),
      .d       (acc_d),
      .q       (acc)
   );

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      mul_start = 1'b0;
      res_valid = 1'b0;
      accept    = 1'b0;
      acc_en    = 1'b0;
      acc_clr   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept   = 1'b1;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            mul_start = 1'b1;
            state_nx  = WAIT;
         end
         WAIT: begin
            // The first WAIT cycle may still see done from the previous product.
            if (mul_done && !first_wait) begin
               acc_en   = 1'b1;
               state_nx = op_last ? HOLD : IDLE;
            end
         end
         HOLD: begin
            res_valid = 1'b1;
            if (res_ready) begin
               acc_clr  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state      <= IDLE;
         op_a       <= '0;
         op_b       <= '0;
         op_last    <= 1'b0;
         first_wait <= 1'b0;
         count      <= '0;
      end else begin
         state      <= state_nx;
         first_wait <= (state == ISSUE);
         if (accept) begin
            op_a    <= in_A;
            op_b    <= in_B;
            op_last <= in_last;
         end
         if (acc_clr) begin
            count <= '0;
         end else if (acc_en) begin
            count <= sat_inc(count);
         end
      end
   end

   assign mul_A     = op_a;
   assign mul_B     = op_b;
   assign res_sum   = acc;
   assign res_count = count;
   assign dbg_state = state;

endmodule
